// File: rtl/msdap_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : msdap_fetch_unit
// Description : Front end of the MSDAP Calculation stage. It loads the rj and
//               coefficient tables, keeps a circular history of incoming
//               samples, and answers each readyForData request with the
//               coefficient sign and the delayed sample x(n-k). It also
//               sequences Calculation per output sample through calc_reset.
// Options     : FETCH_ZERO_PAD_EN - when defined, a fetch with n < k returns
//               inData=0 with validData=1 instead of validData=0.
// Revision    : 1.0 - initial release
// ============================================================================
module msdap_fetch_unit #(
  parameter int DATA_W     = 16,
  parameter int RJ_N       = 16,
  parameter int COEFF_N    = 512,
  parameter int HIST_DEPTH = 256,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] load_word,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              readyForData,
  input  logic              thisNCompleted,
  output logic              calc_reset,
  output logic [DATA_W-1:0] inData,
  output logic              validData,
  output logic              inCoeffSign,
  input  logic [3:0]        rj_rd_idx,
  output logic [7:0]        rj_rd_data,
  output logic [15:0]       n_index,
  output logic [3:0]        status
);

  localparam int CIDX_W  = $clog2(COEFF_N);
  localparam int RJ_AW   = $clog2(RJ_N);
  localparam int HIST_AW = $clog2(HIST_DEPTH);
  localparam int CLR_W   = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOAD_RJ     = 3'd1;
  localparam logic [2:0] S_LOAD_COEFF  = 3'd2;
  localparam logic [2:0] S_WAIT_SAMPLE = 3'd3;
  localparam logic [2:0] S_CLEAR       = 3'd4;
  localparam logic [2:0] S_SERVE       = 3'd5;

  // Storage: never reset, a full reload follows every reset
  logic [DATA_W-1:0] rj_mem    [RJ_N];
  logic [DATA_W-1:0] coeff_mem [COEFF_N];
  logic [DATA_W-1:0] hist_mem  [HIST_DEPTH];

  logic [2:0]        state_q,     state_d;
  logic [CIDX_W-1:0] cnt_q,       cnt_d;
  logic [CLR_W-1:0]  clr_cnt_q,   clr_cnt_d;
  logic [CIDX_W-1:0] coeff_idx_q, coeff_idx_d;
  logic [15:0]       n_q,         n_d;
  logic              filled_q,    filled_d;
  logic              overrun_q,   overrun_d;
  logic [DATA_W-1:0] in_data_q,   in_data_d;
  logic              valid_q,     valid_d;
  logic              sign_q,      sign_d;
  logic              rfd_s_q,     rfd_s_d;
  logic              rfd_p_q,     rfd_p_d;
  logic              tnc_s_q,     tnc_s_d;
  logic              tnc_p_q,     tnc_p_d;

  logic [DATA_W-1:0] w_coeff;
  logic [7:0]        w_k;
  logic [16:0]       w_diff;
  logic              w_before_start;
  logic [DATA_W-1:0] w_hist_rd;
  logic [DATA_W-1:0] w_rj_word;
  logic              w_rfd_edge;
  logic              w_tnc_edge;
  logic              w_unused_bits;

  // Fetch datapath: 17-bit signed n-k; bit 16 set means n-k is negative.
  // Once the history has filled, a wrapped 16-bit n is never "before start".
  assign w_coeff        = coeff_mem[coeff_idx_q];
  assign w_k            = w_coeff[7:0];
  assign w_diff         = {1'b0, n_q} - {9'd0, w_k};
  assign w_before_start = w_diff[16] & ~filled_q;
  assign w_hist_rd      = hist_mem[w_diff[HIST_AW-1:0]];

  assign w_rfd_edge = rfd_s_q & ~rfd_p_q;
  assign w_tnc_edge = tnc_s_q & ~tnc_p_q;

  assign w_rj_word     = rj_mem[rj_rd_idx];
  assign rj_rd_data    = w_rj_word[7:0];
  assign w_unused_bits = ^{w_coeff[DATA_W-1:9], w_rj_word[DATA_W-1:8], w_diff[15:HIST_AW]};

  assign load_ready   = (state_q == S_LOAD_RJ) || (state_q == S_LOAD_COEFF);
  assign sample_ready = (state_q == S_WAIT_SAMPLE);
  assign calc_reset   = (state_q != S_SERVE);
  assign inData       = in_data_q;
  assign validData    = valid_q;
  assign inCoeffSign  = sign_q;
  assign n_index      = n_q;
  assign status       = {overrun_q, state_q};

  // Next-state logic: load sequencing, per-sample clear, and fetch serving
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_cnt_d   = clr_cnt_q;
    coeff_idx_d = coeff_idx_q;
    n_d         = n_q;
    filled_d    = filled_q | (n_q >= 16'(HIST_DEPTH - 1));
    overrun_d   = overrun_q;
    in_data_d   = in_data_q;
    valid_d     = valid_q;
    sign_d      = sign_q;
    rfd_s_d     = readyForData;
    rfd_p_d     = rfd_s_q;
    tnc_s_d     = thisNCompleted;
    tnc_p_d     = tnc_s_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD_RJ;
        cnt_d   = '0;
      end
      S_LOAD_RJ: begin
        if (load_valid) begin
          if (cnt_q == CIDX_W'(RJ_N - 1)) begin
            state_d = S_LOAD_COEFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_COEFF: begin
        if (load_valid) begin
          if (cnt_q == CIDX_W'(COEFF_N - 1)) begin
            state_d = S_WAIT_SAMPLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WAIT_SAMPLE: begin
        if (sample_valid) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        coeff_idx_d = '0;
        valid_d     = 1'b0;
        if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = S_SERVE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_SERVE: begin
        // End of y(n) takes priority over a coincident fetch request
        if (w_tnc_edge) begin
          n_d     = n_q + 16'd1;
          state_d = S_WAIT_SAMPLE;
        end else if (w_rfd_edge) begin
          sign_d      = w_coeff[8];
          coeff_idx_d = coeff_idx_q + 1'b1;
          if (coeff_idx_q == {CIDX_W{1'b1}}) begin
            overrun_d = 1'b1;
          end
`ifdef FETCH_ZERO_PAD_EN
          if (w_before_start) begin
            in_data_d = '0;
            valid_d   = 1'b1;
          end else begin
            in_data_d = w_hist_rd;
            valid_d   = 1'b1;
          end
`else
          if (w_before_start) begin
            valid_d = 1'b0;
          end else begin
            in_data_d = w_hist_rd;
            valid_d   = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      clr_cnt_q   <= '0;
      coeff_idx_q <= '0;
      n_q         <= '0;
      filled_q    <= 1'b0;
      overrun_q   <= 1'b0;
      in_data_q   <= '0;
      valid_q     <= 1'b0;
      sign_q      <= 1'b0;
      rfd_s_q     <= 1'b0;
      rfd_p_q     <= 1'b0;
      tnc_s_q     <= 1'b0;
      tnc_p_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      coeff_idx_q <= coeff_idx_d;
      n_q         <= n_d;
      filled_q    <= filled_d;
      overrun_q   <= overrun_d;
      in_data_q   <= in_data_d;
      valid_q     <= valid_d;
      sign_q      <= sign_d;
      rfd_s_q     <= rfd_s_d;
      rfd_p_q     <= rfd_p_d;
      tnc_s_q     <= tnc_s_d;
      tnc_p_q     <= tnc_p_d;
    end
  end

  // Table and history writes for accepted load words and samples
  always_ff @(posedge clk) begin
    if ((state_q == S_LOAD_RJ) && load_valid) begin
      rj_mem[cnt_q[RJ_AW-1:0]] <= load_word;
    end
    if ((state_q == S_LOAD_COEFF) && load_valid) begin
      coeff_mem[cnt_q] <= load_word;
    end
    if ((state_q == S_WAIT_SAMPLE) && sample_valid) begin
      hist_mem[n_q[HIST_AW-1:0]] <= sample_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msdap_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_msdap_fetch_unit
// Description : Directed, table-driven bench for msdap_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msdap_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] load_word;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        readyForData;
  logic        thisNCompleted;
  logic        calc_reset;
  logic [15:0] inData;
  logic        validData;
  logic        inCoeffSign;
  logic [3:0]  rj_rd_idx;
  logic [7:0]  rj_rd_data;
  logic [15:0] n_index;
  logic [3:0]  status;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          n;
    int          idx;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_sign;
  } vec_t;

  msdap_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .load_word      (load_word),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .readyForData   (readyForData),
    .thisNCompleted (thisNCompleted),
    .calc_reset     (calc_reset),
    .inData         (inData),
    .validData      (validData),
    .inCoeffSign    (inCoeffSign),
    .rj_rd_idx      (rj_rd_idx),
    .rj_rd_data     (rj_rd_data),
    .n_index        (n_index),
    .status         (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] coeff_word(input int i);
    if (i == 3) return 16'h0105;
    return 16'(i & 8'hFF);
  endfunction

  // One readyForData pulse; returns once the fetch result is visible
  task automatic do_fetch();
    @(negedge clk); readyForData = 1'b1;
    @(negedge clk);
    @(negedge clk); readyForData = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_edges(input logic rfd, input logic tnc);
    @(negedge clk); readyForData = rfd; thisNCompleted = tnc;
    @(negedge clk);
    @(negedge clk); readyForData = 1'b0; thisNCompleted = 1'b0;
    @(negedge clk);
  endtask

  // Waits for sample_ready, delivers one sample, and reports how long CLEAR lasted
  task automatic send_sample(input logic [15:0] v, output int clr, output int hi);
    int g;
    g = 0; clr = 0; hi = 0;
    @(negedge clk);
    while (!sample_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("sample_ready", 32'(sample_ready), 1);
    sample_in = v; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    while (status[2:0] == 3'd4 && clr < 10) begin
      clr++;
      if (calc_reset) hi++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs[11];
    int   accepted, guard, vp, fetched, clr, hi;
    logic seen;

`ifdef FETCH_ZERO_PAD_EN
    vecs[0]  = '{0,   0,   1'b1, 16'h1234, 1'b0};
    vecs[1]  = '{0,   1,   1'b1, 16'h0000, 1'b0};
    vecs[2]  = '{1,   1,   1'b1, 16'h1234, 1'b0};
    vecs[3]  = '{2,   0,   1'b1, 16'h0002, 1'b0};
    vecs[4]  = '{2,   3,   1'b1, 16'h0000, 1'b1};
`else
    vecs[0]  = '{0,   0,   1'b1, 16'h1234, 1'b0};
    vecs[1]  = '{0,   1,   1'b0, 16'h1234, 1'b0};
    vecs[2]  = '{1,   1,   1'b1, 16'h1234, 1'b0};
    vecs[3]  = '{2,   0,   1'b1, 16'h0002, 1'b0};
    vecs[4]  = '{2,   3,   1'b0, 16'h1234, 1'b1};
`endif
    vecs[5]  = '{4,   4,   1'b1, 16'h1234, 1'b0};
    vecs[6]  = '{10,  3,   1'b1, 16'h0005, 1'b1};
    vecs[7]  = '{256, 0,   1'b1, 16'h0100, 1'b0};
    vecs[8]  = '{256, 1,   1'b1, 16'h00FF, 1'b0};
    vecs[9]  = '{256, 255, 1'b1, 16'h0001, 1'b0};
    vecs[10] = '{299, 255, 1'b1, 16'h002C, 1'b0};

    reset = 1'b0; load_word = '0; load_valid = 1'b0; sample_in = '0; sample_valid = 1'b0;
    readyForData = 1'b0; thisNCompleted = 1'b0; rj_rd_idx = '0;
    repeat (3) @(negedge clk);

    check("rst_load_ready",   32'(load_ready),   0);
    check("rst_sample_ready", 32'(sample_ready), 0);
    check("rst_calc_reset",   32'(calc_reset),   1);
    check("rst_inData",       32'(inData),       0);
    check("rst_validData",    32'(validData),    0);
    check("rst_inCoeffSign",  32'(inCoeffSign),  0);
    check("rst_n_index",      32'(n_index),      0);
    check("rst_status",       32'(status),       0);
    reset = 1'b1;

    // Load 16 rj words then 512 coefficients
    accepted = 0; guard = 0;
    while (accepted < 528 && guard < 4000) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_word  = (accepted < 16) ? 16'(accepted + 1) : coeff_word(accepted - 16);
      seen = load_ready;
      @(posedge clk);
      if (seen) accepted++;
      guard++;
    end
    @(negedge clk); load_valid = 1'b0;
    check("load_count",       32'(accepted),    528);
    check("state_after_load", 32'(status[2:0]), 3);
    check("load_ready_done",  32'(load_ready),  0);
    check("calc_reset_wait",  32'(calc_reset),  1);
    rj_rd_idx = 4'd15; #1;
    check("rj15", 32'(rj_rd_data), 32'h10);
    rj_rd_idx = 4'd0; #1;
    check("rj0", 32'(rj_rd_data), 32'h01);
    rj_rd_idx = 4'd7; #1;
    check("rj7", 32'(rj_rd_data), 32'h08);

    // Stream x(0)=0x1234, x(n)=n afterwards, checking table entries on the way
    vp = 0;
    for (int n = 0; n < 300; n++) begin
      send_sample((n == 0) ? 16'h1234 : 16'(n), clr, hi);
      check("n_index", 32'(n_index), 32'(n));
      if (n < 2) begin
        check("clear_cycles",   32'(clr),         2);
        check("clear_calc_rst", 32'(hi),          2);
        check("serve_state",    32'(status[2:0]), 5);
        check("serve_calc_rst", 32'(calc_reset),  0);
        check("serve_valid0",   32'(validData),   0);
      end
      fetched = 0;
      while (vp < 11 && vecs[vp].n == n) begin
        while (fetched <= vecs[vp].idx) begin
          do_fetch();
          fetched++;
        end
        check($sformatf("vec%0d_valid", vp), 32'(validData),   32'(vecs[vp].exp_valid));
        check($sformatf("vec%0d_data",  vp), 32'(inData),      32'(vecs[vp].exp_data));
        check($sformatf("vec%0d_sign",  vp), 32'(inCoeffSign), 32'(vecs[vp].exp_sign));
        vp++;
      end
      pulse_edges(1'b0, 1'b1);
    end

    // Coincident readyForData and thisNCompleted: n advances, fetch dropped
    send_sample(16'd300, clr, hi);
    do_fetch();
    check("n300_data",  32'(inData),    32'h012C);
    check("n300_valid", 32'(validData), 1);
    pulse_edges(1'b1, 1'b1);
    check("coinc_n",      32'(n_index),     301);
    check("coinc_state",  32'(status[2:0]), 3);
    check("coinc_data",   32'(inData),      32'h012C);
    check("coinc_valid",  32'(validData),   1);
    check("coinc_calcrs", 32'(calc_reset),  1);

    // 513 fetches in one n set the sticky overrun flag
    send_sample(16'd301, clr, hi);
    repeat (511) do_fetch();
    check("overrun_511", 32'(status[3]), 0);
    do_fetch();
    do_fetch();
    check("overrun_513",    32'(status[3]), 1);
    check("wrap_fetch_dat", 32'(inData),    32'h012D);

    // Reset mid-SERVE takes effect without waiting for a clock edge
    @(negedge clk); reset = 1'b0; #1;
    check("async_status",     32'(status),     0);
    check("async_calc_reset", 32'(calc_reset), 1);
    check("async_n_index",    32'(n_index),    0);
    check("async_validData",  32'(validData),  0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("reload_state",      32'(status[2:0]), 1);
    check("reload_load_ready", 32'(load_ready),  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
